sysx_master_v2: RTL and testbench

sysX version 2 master controller. It sits between the epRISC core's memory-mapped I/O space and the byte-wide sysX peripheral bus.
- Generalises the v1 controller to CHANNELS selectable peripherals.
- Adds buffered TX/RX word FIFOs, a programmable bus clock divider and per-channel maskable interrupts.
- Each queued 32-bit word is shifted out as four byte phases while four MISO bytes are captured in lockstep.

---
 rtl/sysx_pkg.sv | 43 ++++
 rtl/sysx_fifo.sv | 46 ++++
 rtl/sysx_master_v2.sv | 207 ++++++++++++++++++++
 tb/tb_sysx_master_v2.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysx_pkg.sv
// Shared definitions for the sysX v2 master: FSM states, register map and field positions.
// Word fields are numbered big-endian like the core: field bit i lives at vector bit 31-i.
package sysx_pkg;

    typedef enum logic [2:0] {
        PIPE_IDLE      = 3'd0,
        PIPE_BEGIN     = 3'd1,
        PIPE_HIGH_HIGH = 3'd2,
        PIPE_HIGH      = 3'd3,
        PIPE_LOW       = 3'd4,
        PIPE_LOW_LOW   = 3'd5,
        PIPE_END       = 3'd6
    } state_t;

    localparam logic [2:0] ADDR_CONFIG  = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_TXDATA  = 3'd2;
    localparam logic [2:0] ADDR_RXDATA  = 3'd3;
    localparam logic [2:0] ADDR_TXCOUNT = 3'd4;
    localparam logic [2:0] ADDR_RXCOUNT = 3'd5;
    localparam logic [2:0] ADDR_IRQMASK = 3'd6;
    localparam logic [2:0] ADDR_IRQPEND = 3'd7;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_RX_EMPTY = 4;
    localparam int STAT_TX_OVF   = 5;
    localparam int STAT_RX_UDF   = 6;

    localparam int CFG_ENABLE = 0;
    localparam int CFG_IRQ_EN = 1;
    localparam int CFG_CHAN   = 2;
    localparam int CFG_DIV    = 8;

    localparam logic [31:0] FILL_WORD = 32'h0BAD_C0DE;

    function automatic int be_bit(input int i);
        return 31 - i;
    endfunction

endpackage

// File: rtl/sysx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module sysx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sysx_master_v2.sv
// sysX v2 master: memory-mapped register file, TX/RX word FIFOs and the byte-serial bus engine.
// Per-channel vectors (select, interrupt) count channel 0 from the MSB, like the core's words.
module sysx_master_v2
    import sysx_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic [2:0]          iAddress,
    input  logic [31:0]         iData,
    output logic [31:0]         oData,
    input  logic                iWrite,
    input  logic                iRead,
    output logic                oInterrupt,
    input  logic [7:0]          iBusMISO,
    output logic [7:0]          oBusMOSI,
    output logic                oBusClock,
    output logic [CHANNELS-1:0] oBusSelect,
    input  logic [CHANNELS-1:0] iBusInterrupt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CHANNELS-1:0] SEL_MSB = CHANNELS'(1) << (CHANNELS - 1);

    logic                 cfg_enable, cfg_irq_en;
    logic [2:0]           cfg_channel;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [CHANNELS-1:0]  irq_mask, irq_pend;
    logic                 tx_ovf, rx_udf;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [31:0]   tx_dout, rx_dout;
    logic [CW-1:0] tx_count, rx_count;

    state_t               state, state_next;
    logic                 start, half, byte_phase, busy, chan_valid, phase_end;
    logic [1:0]           lane;
    logic [2:0]           chan_q;
    logic [DIV_WIDTH-1:0] div_q, cnt;
    logic [31:0]          tx_sh, rx_sh, rd_data;

    sysx_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(iClock), .rst_n(iReset), .push(tx_push), .pop(tx_pop), .din(iData),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sysx_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(iClock), .rst_n(iReset), .push(rx_push), .pop(rx_pop), .din(rx_sh),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    assign tx_push    = iWrite && (iAddress == ADDR_TXDATA);
    assign rx_pop     = iRead && (iAddress == ADDR_RXDATA);
    assign busy       = (state != PIPE_IDLE);
    assign chan_valid = (int'(cfg_channel) < CHANNELS);
    assign phase_end  = half && (cnt == div_q);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) irq_pend[c] = iBusInterrupt[CHANNELS-1-c] & irq_mask[c];
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        rx_push    = 1'b0;
        case (state)
            PIPE_IDLE: if (cfg_enable && !tx_empty && !rx_full && chan_valid) begin
                state_next = PIPE_BEGIN;
                start      = 1'b1;
            end
            PIPE_BEGIN:     if (phase_end) state_next = PIPE_HIGH_HIGH;
            PIPE_HIGH_HIGH: if (phase_end) state_next = PIPE_HIGH;
            PIPE_HIGH:      if (phase_end) state_next = PIPE_LOW;
            PIPE_LOW:       if (phase_end) state_next = PIPE_LOW_LOW;
            PIPE_LOW_LOW:   if (phase_end) state_next = PIPE_END;
            PIPE_END: if (phase_end) begin
                state_next = PIPE_IDLE;
                rx_push    = 1'b1;
            end
            default: state_next = PIPE_IDLE;
        endcase
    end
    assign tx_pop = start;

    always_comb begin
        byte_phase = 1'b1;
        lane       = 2'd0;
        case (state)
            PIPE_HIGH_HIGH: lane = 2'd0;
            PIPE_HIGH:      lane = 2'd1;
            PIPE_LOW:       lane = 2'd2;
            PIPE_LOW_LOW:   lane = 2'd3;
            default:        byte_phase = 1'b0;
        endcase
    end

    assign oBusClock  = byte_phase & half;
    assign oBusMOSI   = byte_phase ? tx_sh[{~lane, 3'b000} +: 8] : 8'h00;
    assign oBusSelect = busy ? ~(SEL_MSB >> chan_q) : '1;

    // Each state spends DIV+1 cycles with half=0, then DIV+1 with half=1.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state  <= PIPE_IDLE;
            half   <= 1'b0;
            cnt    <= '0;
            div_q  <= '0;
            chan_q <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                half   <= 1'b0;
                cnt    <= '0;
                div_q  <= cfg_div;
                chan_q <= cfg_channel;
                tx_sh  <= tx_dout;
            end else if (busy) begin
                if (cnt == div_q) begin
                    cnt  <= '0;
                    half <= ~half;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (byte_phase && half && (cnt == '0)) rx_sh[{~lane, 3'b000} +: 8] <= iBusMISO;
        end
    end

    always_comb begin
        rd_data = FILL_WORD;
        case (iAddress)
            ADDR_CONFIG: begin
                rd_data = '0;
                rd_data[be_bit(CFG_ENABLE)]           = cfg_enable;
                rd_data[be_bit(CFG_IRQ_EN)]           = cfg_irq_en;
                rd_data[be_bit(CFG_CHAN) -: 3]        = cfg_channel;
                rd_data[be_bit(CFG_DIV) -: DIV_WIDTH] = cfg_div;
            end
            ADDR_STATUS: begin
                rd_data = '0;
                rd_data[be_bit(STAT_BUSY)]     = busy;
                rd_data[be_bit(STAT_TX_FULL)]  = tx_full;
                rd_data[be_bit(STAT_TX_EMPTY)] = tx_empty;
                rd_data[be_bit(STAT_RX_FULL)]  = rx_full;
                rd_data[be_bit(STAT_RX_EMPTY)] = rx_empty;
                rd_data[be_bit(STAT_TX_OVF)]   = tx_ovf;
                rd_data[be_bit(STAT_RX_UDF)]   = rx_udf;
            end
            ADDR_RXDATA:  rd_data = rx_empty ? FILL_WORD : rx_dout;
            ADDR_TXCOUNT: rd_data = 32'(tx_count);
            ADDR_RXCOUNT: rd_data = 32'(rx_count);
            ADDR_IRQMASK: begin
                rd_data = '0;
                for (int c = 0; c < CHANNELS; c++) rd_data[be_bit(c)] = irq_mask[c];
            end
            ADDR_IRQPEND: begin
                rd_data = '0;
                for (int c = 0; c < CHANNELS; c++) rd_data[be_bit(c)] = irq_pend[c];
            end
            default: rd_data = FILL_WORD;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            cfg_enable  <= 1'b0;
            cfg_irq_en  <= 1'b0;
            cfg_channel <= '0;
            cfg_div     <= '0;
            irq_mask    <= '0;
            tx_ovf      <= 1'b0;
            rx_udf      <= 1'b0;
            oData       <= '0;
            oInterrupt  <= 1'b0;
        end else begin
            if (iWrite) begin
                case (iAddress)
                    ADDR_CONFIG: begin
                        cfg_enable  <= iData[be_bit(CFG_ENABLE)];
                        cfg_irq_en  <= iData[be_bit(CFG_IRQ_EN)];
                        cfg_channel <= iData[be_bit(CFG_CHAN) -: 3];
                        cfg_div     <= iData[be_bit(CFG_DIV) -: DIV_WIDTH];
                    end
                    ADDR_STATUS: begin
                        if (iData[be_bit(STAT_TX_OVF)]) tx_ovf <= 1'b0;
                        if (iData[be_bit(STAT_RX_UDF)]) rx_udf <= 1'b0;
                    end
                    ADDR_IRQMASK: for (int c = 0; c < CHANNELS; c++) irq_mask[c] <= iData[be_bit(c)];
                    default: ;
                endcase
            end
            if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
            if (iRead) begin
                oData <= rd_data;
                if (rx_pop && rx_empty) rx_udf <= 1'b1;
            end
            oInterrupt <= cfg_irq_en && (!rx_empty || (tx_empty && !busy) || (|irq_pend));
        end
    end

endmodule

// File: tb/tb_sysx_master_v2.sv
// Self-checking bench for sysx_master_v2: register-level stimulus plus a bus peripheral model
// that scoreboards MOSI words, select pattern and select-low duration against queued expectations.
module tb_sysx_master_v2;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [2:0]  iAddress;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        iWrite, iRead;
    logic        oInterrupt;
    logic [7:0]  iBusMISO = 8'h00;
    logic [7:0]  oBusMOSI;
    logic        oBusClock;
    logic [3:0]  oBusSelect;
    logic [3:0]  iBusInterrupt;

    sysx_master_v2 #(.CHANNELS(4), .FIFO_DEPTH(8), .DIV_WIDTH(8)) dut (
        .iClock(iClock), .iReset(iReset), .iAddress(iAddress), .iData(iData), .oData(oData),
        .iWrite(iWrite), .iRead(iRead), .oInterrupt(oInterrupt), .iBusMISO(iBusMISO),
        .oBusMOSI(oBusMOSI), .oBusClock(oBusClock), .oBusSelect(oBusSelect),
        .iBusInterrupt(iBusInterrupt)
    );

    always #5 iClock = ~iClock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected STATUS bits (big-endian field index i -> vector bit 31-i)
    localparam logic [31:0] ST_BUSY = 32'h8000_0000, ST_TXF = 32'h4000_0000, ST_TXE = 32'h2000_0000;
    localparam logic [31:0] ST_RXE = 32'h0800_0000, ST_OVF = 32'h0400_0000, ST_UDF = 32'h0200_0000;

    function automatic logic [31:0] cfg(input bit en, input bit irq, input int ch, input int div);
        return (32'(en) << 31) | (32'(irq) << 30) | (32'(ch) << 27) | (32'(div) << 16);
    endfunction

    logic [31:0] mosi_q[$];
    logic [31:0] miso_q[$];
    logic [31:0] rx_q[$];
    logic [3:0]  exp_sel = 4'hF;
    int          exp_cycles = 0;
    int          words_done = 0;
    int          bytes_seen = 0;

    // Peripheral model: supplies MISO bytes, collects MOSI bytes on each bus clock rise.
    logic        in_word = 1'b0, clk_prev = 1'b0;
    logic [31:0] cur_miso, mosi_acc;
    int          sel_cycles, byte_idx;
    always @(negedge iClock) begin
        if (iReset !== 1'b1) begin
            in_word  = 1'b0;
            clk_prev = 1'b0;
            iBusMISO = 8'h00;
        end else begin
            if (oBusSelect != 4'hF) begin
                if (!in_word) begin
                    in_word    = 1'b1;
                    cur_miso   = (miso_q.size() > 0) ? miso_q.pop_front() : 32'h0;
                    mosi_acc   = '0;
                    sel_cycles = 0;
                    byte_idx   = 0;
                    bytes_seen = 0;
                    iBusMISO   = cur_miso[31:24];
                end
                sel_cycles++;
                if (oBusClock && !clk_prev) begin
                    mosi_acc = {mosi_acc[23:0], oBusMOSI};
                    bytes_seen++;
                    check("bus_select", 32'(oBusSelect), 32'(exp_sel));
                end
                if (!oBusClock && clk_prev && byte_idx < 3) begin
                    byte_idx++;
                    iBusMISO = cur_miso[8*(3-byte_idx) +: 8];
                end
            end else if (in_word) begin
                in_word = 1'b0;
                check("sel_cycles", 32'(sel_cycles), 32'(exp_cycles));
                if (mosi_q.size() > 0) check("mosi_word", mosi_acc, mosi_q.pop_front());
                else check("mosi_queue", 32'(mosi_q.size()), 32'd1);
                words_done++;
            end
            clk_prev = oBusClock;
        end
    end

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge iClock);
        iAddress = a; iData = d; iWrite = 1'b1;
        @(negedge iClock);
        iWrite = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge iClock);
        iAddress = a; iRead = 1'b1;
        @(negedge iClock);
        iRead = 1'b0;
        d = oData;
    endtask

    task automatic push_word(input logic [31:0] w, input logic [31:0] m);
        reg_write(3'd2, w);
        if (mosi_q.size() < 8) begin
            mosi_q.push_back(w);
            miso_q.push_back(m);
            rx_q.push_back(m);
        end
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words_done < n && k < budget) begin
            @(negedge iClock);
            k++;
        end
        check("wait_words", 32'(words_done), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] d;
    int k;
    initial begin
        iReset = 1'b0; iAddress = '0; iData = '0; iWrite = 1'b0; iRead = 1'b0; iBusInterrupt = '0;
        repeat (3) @(negedge iClock);
        check("rst_select", 32'(oBusSelect), 32'hF);
        check("rst_clock", 32'(oBusClock), 32'h0);
        check("rst_mosi", 32'(oBusMOSI), 32'h0);
        check("rst_odata", oData, 32'h0);
        check("rst_irq", 32'(oInterrupt), 32'h0);
        iReset = 1'b1;
        reg_read(3'd1, d); check("rst_status", d, ST_TXE | ST_RXE);
        reg_read(3'd7, d); check("rst_irqpend", d, 32'h0);
        reg_read(3'd0, d); check("rst_config", d, 32'h0);

        // One word on channel 2, DIV=0
        exp_sel = 4'b1101; exp_cycles = 12;
        reg_write(3'd0, cfg(1, 0, 2, 0));
        reg_read(3'd0, d); check("config_rb", d, cfg(1, 0, 2, 0));
        push_word(32'hA1B2_C3D4, 32'h1122_3344);
        wait_words(1, 100);
        reg_read(3'd3, d); check("rx_word0", d, rx_q.pop_front());
        reg_read(3'd1, d); check("status_idle", d, ST_TXE | ST_RXE);

        // Two back-to-back words on channel 0, DIV=1
        exp_sel = 4'b0111; exp_cycles = 24;
        reg_write(3'd0, cfg(1, 0, 0, 1));
        push_word(32'h5A0F_F0A5, 32'hDEAD_BEEF);
        push_word(32'h0123_4567, 32'h89AB_CDEF);
        wait_words(3, 200);
        reg_read(3'd5, d); check("rxcount_2", d, 32'd2);
        for (int i = 0; i < 2; i++) begin
            reg_read(3'd3, d); check("rx_word", d, rx_q.pop_front());
        end

        // Overflow with the engine disabled
        reg_write(3'd0, 32'h0);
        for (int i = 0; i < 9; i++) push_word(32'h1000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
        reg_read(3'd4, d); check("txcount_full", d, 32'd8);
        reg_read(3'd1, d); check("status_ovf", d, ST_TXF | ST_RXE | ST_OVF);
        reg_write(3'd1, ST_OVF);
        reg_read(3'd1, d); check("ovf_clear", d, ST_TXF | ST_RXE);

        // Underflow
        reg_read(3'd3, d); check("rx_empty_fill", d, 32'h0BAD_C0DE);
        reg_read(3'd1, d); check("status_udf", d, ST_TXF | ST_RXE | ST_UDF);
        reg_write(3'd1, ST_UDF);
        reg_read(3'd1, d); check("udf_clear", d, ST_TXF | ST_RXE);

        // Maskable interrupts: only channel 2 enabled
        reg_write(3'd0, cfg(0, 1, 0, 0));
        reg_write(3'd6, 32'h2000_0000);
        reg_read(3'd6, d); check("irqmask_rb", d, 32'h2000_0000);
        iBusInterrupt = 4'b0100;
        repeat (2) @(negedge iClock);
        check("irq_ch1_masked", 32'(oInterrupt), 32'h0);
        reg_read(3'd7, d); check("irqpend_ch1", d, 32'h0);
        iBusInterrupt = 4'b0110;
        @(negedge iClock);
        check("irq_ch2", 32'(oInterrupt), 32'h1);
        reg_read(3'd7, d); check("irqpend_ch2", d, 32'h2000_0000);
        iBusInterrupt = 4'b0000;
        repeat (2) @(negedge iClock);
        check("irq_release", 32'(oInterrupt), 32'h0);

        // Reset in the middle of the High byte, DIV=3 on channel 1
        exp_sel = 4'b1011; exp_cycles = 48;
        reg_write(3'd0, cfg(1, 0, 1, 3));
        k = 0;
        while (!(in_word && bytes_seen >= 2) && k < 300) begin
            @(negedge iClock);
            k++;
        end
        check("reach_high_byte", 32'(bytes_seen >= 2), 32'h1);
        iReset = 1'b0;
        @(negedge iClock);
        check("midrst_select", 32'(oBusSelect), 32'hF);
        check("midrst_clock", 32'(oBusClock), 32'h0);
        check("midrst_mosi", 32'(oBusMOSI), 32'h0);
        @(negedge iClock);
        iReset = 1'b1;
        mosi_q.delete(); miso_q.delete(); rx_q.delete();
        reg_read(3'd4, d); check("midrst_txcount", d, 32'd0);
        reg_read(3'd5, d); check("midrst_rxcount", d, 32'd0);
        reg_read(3'd1, d); check("midrst_status", d, ST_TXE | ST_RXE);
        reg_read(3'd0, d); check("midrst_config", d, 32'h0);
        reg_read(3'd6, d); check("midrst_irqmask", d, 32'h0);
        repeat (4) @(negedge iClock);
        check("midrst_idle_select", 32'(oBusSelect), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
